// File: rtl/pulse_gen_if.sv
// -----------------------------------------------------------------------------
// pulse_gen_if
// Configuration handshake between a controller and pulse_gen.
//   cfg_valid  : controller offers a configuration
//   cfg_ready  : pulse_gen can take a configuration this cycle
//   cfg_period : period in clock cycles
//   cfg_high   : high time in clock cycles
//   cfg_count  : pulses per run, 0 = continuous
// A configuration transfers on a cycle where cfg_valid && cfg_ready.
// -----------------------------------------------------------------------------
interface pulse_gen_if;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [31:0] cfg_period;
   logic [31:0] cfg_high;
   logic [15:0] cfg_count;

   modport master (
      output cfg_valid, cfg_period, cfg_high, cfg_count,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_period, cfg_high, cfg_count,
      output cfg_ready
   );
endinterface

// File: rtl/pulse_gen.sv
// -----------------------------------------------------------------------------
// pulse_gen
// Programmable pulse-train generator. pulse_out is high for `high` cycles and
// low for `period - high` cycles, for `count` pulses or continuously when
// count is 0. New configurations received mid-run wait in a shadow register
// and are applied only on a period boundary, so no period is ever truncated.
//
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   cfg        : configuration handshake (pulse_gen_if.slave)
//   start      : single-cycle run request (ignored while busy)
//   stop       : single-cycle graceful stop (finishes the current period)
//   pulse_out  : registered pulse output
//   busy       : high while a run is in progress
//   done       : one-cycle strobe in the first idle cycle after a run
//   pulse_idx  : pulses started in the current run, saturating
// -----------------------------------------------------------------------------
module pulse_gen #(
   parameter logic [31:0] DEF_PERIOD = 32'd100000,
   parameter logic [31:0] DEF_HIGH   = 32'd50000
) (
   input  logic        clk,
   input  logic        rst_n,
   pulse_gen_if.slave  cfg,
   input  logic        start,
   input  logic        stop,
   output logic        pulse_out,
   output logic        busy,
   output logic        done,
   output logic [15:0] pulse_idx
);

   typedef enum logic [2:0] {
      S_IDLE = 3'b001,
      S_HIGH = 3'b010,
      S_LOW  = 3'b100
   } state_t;

   typedef struct packed {
      logic [31:0] period;
      logic [31:0] high;
      logic [15:0] count;
   } cfg_t;

   // Forces any configuration into a legal pulse shape: period >= 2 and
   // 1 <= high <= period - 1, so both phases always last at least a cycle.
   function automatic cfg_t clamp_cfg(input cfg_t c);
      cfg_t r;
      r = c;
      if (r.period < 32'd2)    r.period = 32'd2;
      if (r.high == 32'd0)     r.high   = 32'd1;
      if (r.high >= r.period)  r.high   = r.period - 32'd1;
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [31:0] cnt_q;
   cfg_t        act_q;
   cfg_t        pend_q;
   logic        pend_valid_q;
   logic        stop_pend_q;
   cfg_t        cfg_in;
   logic        accept;
   logic        finishing;
   logic        boundary;

   assign cfg_in        = '{period: cfg.cfg_period, high: cfg.cfg_high, count: cfg.cfg_count};
   // Ready is a pure function of a register, so it never depends on cfg_valid.
   assign cfg.cfg_ready = ~pend_valid_q;
   assign accept        = cfg.cfg_valid && !pend_valid_q;
   assign busy          = (state_q != S_IDLE);

   // A stop arriving in the very last cycle of a period still ends the run
   // at that boundary instead of costing one more full period.
   assign finishing = stop_pend_q || stop ||
                      ((act_q.count != 16'd0) && (pulse_idx >= act_q.count));

   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start)                    state_d = S_HIGH;
         S_HIGH:  if (cnt_q == act_q.high)      state_d = S_LOW;
         S_LOW:   if (cnt_q == act_q.period)    state_d = finishing ? S_IDLE : S_HIGH;
         default:                               state_d = S_IDLE;
      endcase
   end

   assign boundary = (state_q == S_LOW) && (state_d == S_HIGH);

   // NOTE: all state below is updated with non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= 32'd0;
         act_q        <= '{period: DEF_PERIOD, high: DEF_HIGH, count: 16'd0};
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         stop_pend_q  <= 1'b0;
         pulse_out    <= 1'b0;
         done         <= 1'b0;
         pulse_idx    <= 16'd0;
      end else begin
         state_q   <= state_d;
         pulse_out <= (state_d == S_HIGH);
         done      <= (state_q == S_LOW) && (state_d == S_IDLE);

         // Counter runs 1..period; it is parked at 0 in IDLE so it can never
         // step past period and overflow.
         if (state_d == S_IDLE)
            cnt_q <= 32'd0;
         else if (state_d == S_HIGH && state_q != S_HIGH)
            cnt_q <= 32'd1;
         else
            cnt_q <= cnt_q + 32'd1;

         if (state_q == S_IDLE && state_d == S_HIGH)
            pulse_idx <= 16'd1;
         else if (boundary && pulse_idx != 16'hFFFF)
            pulse_idx <= pulse_idx + 16'd1;

         if (state_d == S_IDLE)
            stop_pend_q <= 1'b0;
         else if (state_q != S_IDLE && stop)
            stop_pend_q <= 1'b1;

         // In IDLE a config goes straight to active. A config that landed in
         // the shadow on the final edge of a run is applied in IDLE as well,
         // otherwise cfg_ready would stay low until the next run.
         if (state_q == S_IDLE) begin
            if (accept) begin
               act_q <= clamp_cfg(cfg_in);
            end else if (pend_valid_q) begin
               act_q        <= clamp_cfg(pend_q);
               pend_valid_q <= 1'b0;
            end
         end else if (accept) begin
            pend_q       <= cfg_in;
            pend_valid_q <= 1'b1;
         end else if (boundary && pend_valid_q) begin
            act_q        <= clamp_cfg(pend_q);
            pend_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_pulse_gen
// Directed scenarios with hand-computed expectations, followed by randomized
// traffic, all compared every cycle against a reference model that describes
// the pulse train as a position within the current period.
// Small default period/high values keep the default-config scenarios short.
// -----------------------------------------------------------------------------
module tb_pulse_gen;
   localparam logic [31:0] DP = 32'd24;
   localparam logic [31:0] DH = 32'd9;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop  = 1'b0;
   logic        pulse_out, busy, done;
   logic [15:0] pulse_idx;

   pulse_gen_if cfg_if ();

   pulse_gen #(.DEF_PERIOD(DP), .DEF_HIGH(DH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg       (cfg_if),
      .start     (start),
      .stop      (stop),
      .pulse_out (pulse_out),
      .busy      (busy),
      .done      (done),
      .pulse_idx (pulse_idx)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int unsigned p;
      int unsigned h;
      int unsigned c;
   } mcfg_t;

   mcfg_t       m_act;
   mcfg_t       m_q[$];
   bit          m_run  = 1'b0;
   int unsigned m_t    = 0;   // cycles elapsed since the current period began
   int unsigned m_idx  = 0;
   bit          m_stop = 1'b0;

   logic        e_pulse = 1'b0;
   logic        e_busy  = 1'b0;
   logic        e_done  = 1'b0;
   logic        e_ready = 1'b1;
   logic [15:0] e_idx   = 16'd0;

   function automatic mcfg_t legal(input mcfg_t c);
      mcfg_t r;
      r = c;
      if (r.p < 2)    r.p = 2;
      if (r.h == 0)   r.h = 1;
      if (r.h >= r.p) r.h = r.p - 1;
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      bit    acc;
      bit    fin;
      mcfg_t in_cfg;
      if (!rst_n) begin
         m_act.p = DP;
         m_act.h = DH;
         m_act.c = 0;
         m_q.delete();
         m_run  = 1'b0;
         m_t    = 0;
         m_idx  = 0;
         m_stop = 1'b0;
         e_done = 1'b0;
      end else begin
         acc      = cfg_if.cfg_valid && (m_q.size() == 0);
         in_cfg.p = cfg_if.cfg_period;
         in_cfg.h = cfg_if.cfg_high;
         in_cfg.c = {16'd0, cfg_if.cfg_count};
         e_done   = 1'b0;
         if (!m_run) begin
            if (acc)                  m_act = legal(in_cfg);
            else if (m_q.size() != 0) m_act = legal(m_q.pop_front());
            if (start) begin
               m_run  = 1'b1;
               m_t    = 0;
               m_idx  = 1;
               m_stop = 1'b0;
            end
         end else begin
            if (stop) m_stop = 1'b1;
            if (m_t == m_act.p - 1) begin
               fin = m_stop || (m_act.c != 0 && m_idx >= m_act.c);
               if (fin) begin
                  m_run  = 1'b0;
                  m_stop = 1'b0;
                  e_done = 1'b1;
               end else begin
                  m_t = 0;
                  if (m_idx < 65535) m_idx++;
                  if (m_q.size() != 0) m_act = legal(m_q.pop_front());
               end
            end else begin
               m_t++;
            end
            if (acc) m_q.push_back(in_cfg);
         end
      end
      e_busy  = m_run;
      e_pulse = m_run && (m_t < m_act.h);
      e_idx   = m_idx[15:0];
      e_ready = (m_q.size() == 0);
   end

   // ---------------- per-cycle comparison ----------------
   always @(negedge clk) begin
      check("pulse_out", {31'd0, pulse_out}, {31'd0, e_pulse});
      check("busy",      {31'd0, busy},      {31'd0, e_busy});
      check("done",      {31'd0, done},      {31'd0, e_done});
      check("cfg_ready", {31'd0, cfg_if.cfg_ready}, {31'd0, e_ready});
      check("pulse_idx", {16'd0, pulse_idx}, {16'd0, e_idx});
   end

   // ---------------- stimulus helpers ----------------
   task automatic adv(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge of run cycle 1.
   task automatic start_run();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Config and start offered together in one idle cycle.
   task automatic cfg_start(input logic [31:0] p, input logic [31:0] h, input logic [15:0] c);
      cfg_if.cfg_valid  = 1'b1;
      cfg_if.cfg_period = p;
      cfg_if.cfg_high   = h;
      cfg_if.cfg_count  = c;
      start_run();
      cfg_if.cfg_valid  = 1'b0;
   endtask

   task automatic cfg_write(input logic [31:0] p, input logic [31:0] h, input logic [15:0] c);
      cfg_if.cfg_valid  = 1'b1;
      cfg_if.cfg_period = p;
      cfg_if.cfg_high   = h;
      cfg_if.cfg_count  = c;
      @(negedge clk);
      cfg_if.cfg_valid  = 1'b0;
   endtask

   task automatic go_idle();
      int i;
      i = 0;
      if (busy) begin
         stop = 1'b1;
         @(negedge clk);
         stop = 1'b0;
      end
      while (busy && i < 200) begin
         @(negedge clk);
         i++;
      end
      check("reach_idle", {31'd0, busy}, 32'd0);
      @(negedge clk);
   endtask

   initial begin
      cfg_if.cfg_valid  = 1'b0;
      cfg_if.cfg_period = 32'd0;
      cfg_if.cfg_high   = 32'd0;
      cfg_if.cfg_count  = 16'd0;

      // Reset values
      adv(2);
      check("rst_pulse", {31'd0, pulse_out}, 32'd0);
      check("rst_busy",  {31'd0, busy},      32'd0);
      check("rst_done",  {31'd0, done},      32'd0);
      check("rst_idx",   {16'd0, pulse_idx}, 32'd0);
      check("rst_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
      rst_n = 1'b1;
      adv(1);

      // Default continuous run: 24 period, 9 high
      start_run();
      check("def_c1_pulse", {31'd0, pulse_out}, 32'd1);
      check("def_c1_busy",  {31'd0, busy},      32'd1);
      adv(8);  check("def_c9_pulse",  {31'd0, pulse_out}, 32'd1);
      adv(1);  check("def_c10_pulse", {31'd0, pulse_out}, 32'd0);
      adv(15); check("def_c25_pulse", {31'd0, pulse_out}, 32'd1);
      check("def_c25_idx", {16'd0, pulse_idx}, 32'd2);
      adv(24); check("def_c49_idx",   {16'd0, pulse_idx}, 32'd3);
      check("def_c49_busy", {31'd0, busy}, 32'd1);
      go_idle();

      // Finite run 10/3 x4
      cfg_write(32'd10, 32'd3, 16'd4);
      start_run();
      check("fin_c1_idx", {16'd0, pulse_idx}, 32'd1);
      adv(2);  check("fin_c3_pulse",  {31'd0, pulse_out}, 32'd1);
      adv(1);  check("fin_c4_pulse",  {31'd0, pulse_out}, 32'd0);
      adv(7);  check("fin_c11_pulse", {31'd0, pulse_out}, 32'd1);
      check("fin_c11_idx", {16'd0, pulse_idx}, 32'd2);
      adv(29); check("fin_c40_busy",  {31'd0, busy}, 32'd1);
      check("fin_c40_done", {31'd0, done}, 32'd0);
      adv(1);  check("fin_c41_done",  {31'd0, done}, 32'd1);
      check("fin_c41_busy", {31'd0, busy},      32'd0);
      check("fin_c41_idx",  {16'd0, pulse_idx}, 32'd4);
      adv(1);  check("fin_c42_done",  {31'd0, done}, 32'd0);

      // Clamp 1/0 -> 2/1, config and start in the same cycle
      cfg_start(32'd1, 32'd0, 16'd0);
      check("clp1_c1", {31'd0, pulse_out}, 32'd1);
      adv(1); check("clp1_c2", {31'd0, pulse_out}, 32'd0);
      adv(1); check("clp1_c3", {31'd0, pulse_out}, 32'd1);
      check("clp1_c3_idx", {16'd0, pulse_idx}, 32'd2);
      go_idle();

      // Clamp 5/9 -> 5/4, two pulses
      cfg_start(32'd5, 32'd9, 16'd2);
      adv(3); check("clp2_c4", {31'd0, pulse_out}, 32'd1);
      adv(1); check("clp2_c5", {31'd0, pulse_out}, 32'd0);
      adv(1); check("clp2_c6", {31'd0, pulse_out}, 32'd1);
      adv(5); check("clp2_c11_done", {31'd0, done}, 32'd1);
      adv(1);

      // Mid-run reconfiguration 10/3 -> 20/15
      cfg_start(32'd10, 32'd3, 16'd0);
      cfg_write(32'd20, 32'd15, 16'd0);
      check("mid_c2_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
      adv(1);  check("mid_c3_pulse",  {31'd0, pulse_out}, 32'd1);
      adv(1);  check("mid_c4_pulse",  {31'd0, pulse_out}, 32'd0);
      adv(6);  check("mid_c10_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
      adv(1);  check("mid_c11_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
      check("mid_c11_pulse", {31'd0, pulse_out}, 32'd1);
      adv(14); check("mid_c25_pulse", {31'd0, pulse_out}, 32'd1);
      adv(1);  check("mid_c26_pulse", {31'd0, pulse_out}, 32'd0);
      adv(5);  check("mid_c31_pulse", {31'd0, pulse_out}, 32'd1);
      go_idle();

      // Stop in 2nd HIGH cycle of a continuous 10/3 run; start mid-run ignored
      cfg_start(32'd10, 32'd3, 16'd0);
      adv(1); stop = 1'b1;
      adv(1); stop = 1'b0;
      check("stp_c3_pulse", {31'd0, pulse_out}, 32'd1);
      adv(2); start = 1'b1;
      adv(1); start = 1'b0;
      adv(4); check("stp_c10_busy", {31'd0, busy}, 32'd1);
      adv(1); check("stp_c11_done", {31'd0, done}, 32'd1);
      check("stp_c11_busy", {31'd0, busy}, 32'd0);
      check("stp_c11_idx",  {16'd0, pulse_idx}, 32'd1);
      adv(1); check("stp_c12_busy", {31'd0, busy}, 32'd0);

      // Start and stop together in IDLE: start wins
      start = 1'b1; stop = 1'b1;
      adv(1);
      start = 1'b0; stop = 1'b0;
      adv(10); check("ss_c11_busy", {31'd0, busy}, 32'd1);
      go_idle();

      // Reset during HIGH of a 10/3 run
      start_run();
      adv(1);
      #2 rst_n = 1'b0;
      #1;
      check("rmid_pulse", {31'd0, pulse_out}, 32'd0);
      check("rmid_busy",  {31'd0, busy},      32'd0);
      check("rmid_idx",   {16'd0, pulse_idx}, 32'd0);
      check("rmid_done",  {31'd0, done},      32'd0);
      @(negedge clk); rst_n = 1'b1;
      adv(1);
      start_run();
      adv(3); check("rmid_c4_pulse",  {31'd0, pulse_out}, 32'd1);
      adv(6); check("rmid_c10_pulse", {31'd0, pulse_out}, 32'd0);
      go_idle();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         start             = ($urandom_range(0, 15) == 0);
         stop              = ($urandom_range(0, 39) == 0);
         cfg_if.cfg_valid  = ($urandom_range(0, 7) == 0);
         cfg_if.cfg_period = $urandom_range(0, 14);
         cfg_if.cfg_high   = $urandom_range(0, 16);
         cfg_if.cfg_count  = 16'($urandom_range(0, 5));
         if (i == 1500) begin
            #1 rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
         @(negedge clk);
      end
      start            = 1'b0;
      stop             = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      adv(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pulse_gen.md
# pulse_gen

Programmable pulse-train generator, the stimulus-side counterpart of the pulse-period frequency meter in phase_2. It produces `pulse_out` with a cycle-exact period and high time, expressed in system-clock cycles (10 ns at 100 MHz). It can emit a fixed number of pulses or run continuously. Configuration passes through a valid/ready handshake and takes effect only on period boundaries, so the meter never sees a truncated or glitched period.

## Interface
- `DEF_PERIOD`, 100000: active period in cycles after reset (1 kHz).
- `DEF_HIGH`, 50000: active high time in cycles after reset.
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `cfg_valid` in 1: a new configuration is offered.
- `cfg_ready` out 1: a configuration can be accepted. Low only while a pending config is waiting to be applied.
- `cfg_period` in 32: period in cycles.
- `cfg_high` in 32: high time in cycles.
- `cfg_count` in 16: number of pulses per run. 0 means continuous.
- `start` in 1: single-cycle run request.
- `stop` in 1: single-cycle graceful stop request.
- `pulse_out` out 1: registered pulse output.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: single-cycle strobe when a run ends.
- `pulse_idx` out 16: pulses started in the current run, saturating at 16'hFFFF.

## Operation
- **Handshake.** A config is accepted on `cfg_valid && cfg_ready`.
  - In IDLE, the accepted config is copied directly to the active registers (period, high, count).
  - While running, the accepted config goes to a pending shadow and `cfg_ready` drops. At the next period boundary (the transition into HIGH), pending is copied to active and `cfg_ready` returns to 1 on the following cycle.
- **Clamping.** Applied when a config is copied to active, in this order:
  - period < 2 → 2
  - high = 0 → 1
  - high ≥ period → period − 1

  Clamped values are always legal; nothing is rejected.
- **States.** One-hot: IDLE, HIGH, LOW.
  - IDLE → HIGH on `start`. The pulse counter loads to 1 and `pulse_idx` is set to 1.
  - HIGH → LOW when `cnt == high`.
  - LOW → HIGH when `cnt == period` and the run is not finishing. The counter reloads to 1, `pulse_idx` increments, and any pending config is applied.
  - LOW → IDLE when `cnt == period` and the run is finishing. `done` pulses for 1 cycle.
  - A run is finishing when a stop is latched, or when count ≠ 0 and `pulse_idx == count`.
- **Period counter.** 32-bit, counts 1..period across HIGH and LOW. The period wraps exactly to 1 and never overflows, because period ≤ 2^32 − 1.
- **Stop.** `stop` while running sets a `stop_pend` flag. The current period completes in full, then the block returns to IDLE. `stop` in IDLE is ignored.
- **Ignored requests.** `start` while `busy` is ignored.
- **Simultaneous events.**
  - `start` and an accepted config in the same IDLE cycle: the new config is used for the run.
  - `start` and `stop` in the same IDLE cycle: `start` wins. `stop` is ignored, because it is not yet running.
- **Count change mid-run.** Takes effect at the boundary. If the new count is ≤ the current `pulse_idx`, the run ends at the end of the current period.

## Timing
- **Reset values:**
  - `pulse_out` = 0, `busy` = 0, `done` = 0, `pulse_idx` = 0, `cfg_ready` = 1.
  - Active period/high = `DEF_PERIOD`/`DEF_HIGH`, count = 0.
  - Pending shadow empty, `stop_pend` = 0, state IDLE.
- **Reset mid-operation:** all of the above apply immediately and asynchronously. `pulse_out` drops at once; no `done` is produced.
- **Start latency:** `start` sampled at edge N → `pulse_out` = 1 and `busy` = 1 from edge N+1.
- **Pulse shape:** `pulse_out` is high for exactly `high` cycles, then low for `period − high` cycles. Rising edges are exactly `period` cycles apart.
- **End of run:**
  - `done` = 1 in the first IDLE cycle. `busy` = 0 in the same cycle.
  - `pulse_out` is already 0 there, as the last LOW phase has ended.
- **Back-to-back runs:** `start` in the cycle `done` is high begins a new run on the next edge. Minimum gap between runs is 1 idle cycle.
- **`cfg_ready`** is registered. After acceptance mid-run it is 0 from the next cycle until 1 cycle after the boundary.

## Test plan
- **Default continuous run.** Reset, then `start`. Required: rising edges every 100000 cycles, high 50000 cycles; `busy` stays 1; `done` never asserts.
- **Finite run.**
  - Stimulus: IDLE config period 10, high 3, count 4, then `start`.
  - Required: 4 pulses, each 3 high / 7 low; `pulse_idx` steps 1..4; `done` 1 cycle after 40 cycles of activity.
- **Clamping.**
  - period 1, high 0 → 2/1 (toggling pulses).
  - period 5, high 9 → high 4.
- **Mid-run reconfiguration.**
  - Stimulus: during run 10/3, write 20/15 while in HIGH.
  - Required: the current period stays 10/3; the next period is 20/15; `cfg_ready` is low until 1 cycle after the boundary.
- **Stop.** `stop` in the 2nd cycle of HIGH of a continuous 10/3 run. Required: the period completes (3 high, 7 low), then IDLE with `done` = 1. A `start` during the run is ignored.
- **Reset mid-run.** `rst_n` low during HIGH. Required: `pulse_out`, `busy` and `pulse_idx` are 0 immediately; active config returns to `DEF_PERIOD`/`DEF_HIGH`; `done` stays 0.
